// File: rtl/iot_event_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// iot_pkg
// Purpose : shared constants for the IoT event arbiter slice.
// Contents: default device count, default counter widths and the default
//           round-robin pointer width derived from the device count.
// ---------------------------------------------------------------------------
package iot_pkg;

  localparam int N_DEV_DEF  = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int DROP_W_DEF = 8;
  localparam int PTR_W      = $clog2(N_DEV_DEF);

endpackage

// File: rtl/iot_event_arbiter_rr.sv
// ---------------------------------------------------------------------------
// iot_rr_arbiter
// Purpose : purely combinational round-robin picker. Starting at ptr and
//           wrapping around, it selects the first asserted request.
// Ports   : req         - request vector, one bit per device
//           ptr         - index that has the highest priority this cycle
//           enable      - when low, nothing is granted
//           grant       - one-hot grant vector
//           grant_idx   - binary index of the granted device
//           grant_valid - a grant was issued
// ---------------------------------------------------------------------------
module iot_rr_arbiter
  import iot_pkg::*;
#(
  parameter int N  = N_DEV_DEF,
  parameter int PW = PTR_W
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  // The scan walks the priority offsets from lowest priority to highest.
  // Later hits overwrite earlier ones, so the device nearest to ptr wins.
  // This avoids building a double-width rotated vector.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (enable) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (req[PW'(idx)]) begin
          grant_valid = 1'b1;
          grant_idx   = PW'(idx);
        end
      end
      if (grant_valid) grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/iot_event_arbiter.sv
// ---------------------------------------------------------------------------
// iot_event_arbiter
// Purpose : collects on/off requests from N_DEV devices and serialises them,
//           one per cycle, into change/on_off events for the active-device
//           counter. A per-device shadow filters out redundant requests so
//           the counter only ever sees genuine transitions.
// Ports   : clk, rst_n (async, active low)
//           req_valid/req_on/req_ready - per-device request handshake
//           hold         - freezes arbitration; capture keeps running
//           change/on_off- registered event pulse and direction
//           dev_on       - shadow on/off state per device
//           active_count - number of devices currently on
//           drop_cnt     - saturating count of redundant requests
//           busy         - at least one request is pending
// ---------------------------------------------------------------------------
module iot_event_arbiter
  import iot_pkg::*;
#(
  parameter int N_DEV  = N_DEV_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_DEV-1:0]  req_valid,
  input  logic [N_DEV-1:0]  req_on,
  output logic [N_DEV-1:0]  req_ready,
  input  logic              hold,
  output logic              change,
  output logic              on_off,
  output logic [N_DEV-1:0]  dev_on,
  output logic [CNT_W-1:0]  active_count,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  localparam int PW = $clog2(N_DEV);

  logic [N_DEV-1:0] pend;
  logic [N_DEV-1:0] pend_val;
  logic [N_DEV-1:0] capture;
  logic [N_DEV-1:0] grant;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant_idx;
  logic             grant_valid;
  logic             grant_val;
  logic             genuine;

  iot_rr_arbiter #(
    .N  (N_DEV),
    .PW (PW)
  ) u_rr (
    .req         (pend),
    .ptr         (ptr),
    .enable      (!hold),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A device can only be captured while its slot is empty, so capture and
  // grant never touch the same bit in one cycle.
  assign req_ready = ~pend;
  assign busy      = |pend;
  assign capture   = req_valid & ~pend;
  assign grant_val = pend_val[grant_idx];
  assign genuine   = grant_valid && (grant_val != dev_on[grant_idx]);

  // Request slots: the granted slot empties while newly captured slots
  // latch their requested state. A grant and a capture on different
  // devices both take effect on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_val <= '0;
    end else begin
      pend     <= (pend & ~grant) | capture;
      pend_val <= (pend_val & ~capture) | (req_on & capture);
    end
  end

  // The pointer moves just past the last winner, which bounds every
  // device's wait to N_DEV grant cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == PW'(N_DEV - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  // Event generation. Only a real transition pulses change and moves the
  // shadow and the count, so active_count stays within 0..N_DEV. A
  // redundant grant is swallowed and tallied in drop_cnt, which saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change       <= 1'b0;
      on_off       <= 1'b0;
      dev_on       <= '0;
      active_count <= '0;
      drop_cnt     <= '0;
    end else begin
      change <= genuine;
      if (genuine) begin
        on_off            <= grant_val;
        dev_on[grant_idx] <= grant_val;
        if (grant_val) active_count <= active_count + CNT_W'(1);
        else           active_count <= active_count - CNT_W'(1);
      end else if (grant_valid && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iot_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iot_event_arbiter
// Purpose : self-checking bench for iot_event_arbiter (N_DEV=8). Directed
//           steps followed by a random phase, all compared every cycle
//           against a behavioural model of the request/grant rules.
// ---------------------------------------------------------------------------
module tb_iot_event_arbiter;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_valid;
  logic [7:0] req_on;
  logic [7:0] req_ready;
  logic       hold;
  logic       change;
  logic       on_off;
  logic [7:0] dev_on;
  logic [7:0] active_count;
  logic [7:0] drop_cnt;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state, one entry per device
  bit m_pend   [N];
  bit m_val    [N];
  bit m_on     [N];
  int m_ptr;
  bit m_change;
  bit m_on_off;
  int m_drop;

  iot_event_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_on       (req_on),
    .req_ready    (req_ready),
    .hold         (hold),
    .change       (change),
    .on_off       (on_off),
    .dev_on       (dev_on),
    .active_count (active_count),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reset clears every pending request and all model outputs
  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_val[i]  = 1'b0;
      m_on[i]   = 1'b0;
    end
    m_ptr    = 0;
    m_change = 1'b0;
    m_on_off = 1'b0;
    m_drop   = 0;
  endtask

  // One clock edge of the arbiter rules, evaluated on pre-edge state
  task automatic modelStep(input logic [7:0] v, input logic [7:0] o, input logic h);
    bit pre [N];
    int g;
    g = -1;
    for (int i = 0; i < N; i++) pre[i] = m_pend[i];
    if (!h) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pre[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    m_change = 1'b0;
    if (g >= 0) begin
      m_pend[g] = 1'b0;
      m_ptr     = (g + 1) % N;
      if (m_val[g] != m_on[g]) begin
        m_change = 1'b1;
        m_on_off = m_val[g];
        m_on[g]  = m_val[g];
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (v[i] && !pre[i]) begin
        m_pend[i] = 1'b1;
        m_val[i]  = o[i];
      end
    end
  endtask

  function automatic logic [7:0] modelVec(input int which);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = (which == 0) ? m_on[i] : !m_pend[i];
    return r;
  endfunction

  function automatic int modelCount();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += int'(m_on[i]);
    return c;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    compare("change",       {31'b0, change},      {31'b0, m_change});
    compare("on_off",       {31'b0, on_off},      {31'b0, m_on_off});
    compare("dev_on",       {24'b0, dev_on},      {24'b0, modelVec(0)});
    compare("active_count", {24'b0, active_count}, modelCount());
    compare("drop_cnt",     {24'b0, drop_cnt},    m_drop);
    compare("req_ready",    {24'b0, req_ready},   {24'b0, modelVec(1)});
    compare("busy",         {31'b0, busy},        {31'b0, (modelVec(1) != 8'hFF)});
  endtask

  // Drive one cycle of inputs, step the model at the edge, check just after
  task automatic applyStimulus(input logic [7:0] v, input logic [7:0] o, input logic h);
    req_valid = v;
    req_on    = o;
    hold      = h;
    @(posedge clk);
    modelStep(v, o, h);
    #1;
    req_valid = '0;
    req_on    = '0;
    hold      = 1'b0;
    checkOutput();
  endtask

  // Asynchronous reset asserted away from the clock edge
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    compare("reset_ready", {24'b0, req_ready}, 32'hFF);
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_on    = '0;
    hold      = 1'b0;
    #2;
    doReset();

    $display("[TB] single on-request for device 2");
    applyStimulus(8'h04, 8'h04, 1'b0);
    compare("single_no_early_change", {31'b0, change}, 32'h0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    compare("single_change", {31'b0, change}, 32'h1);
    compare("single_dev_on", {24'b0, dev_on}, 32'h04);
    compare("single_count", {24'b0, active_count}, 32'h1);
    applyStimulus(8'h00, 8'h00, 1'b0);
    compare("single_pulse_end", {31'b0, change}, 32'h0);

    $display("[TB] redundant on, then off for device 2");
    applyStimulus(8'h04, 8'h04, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    compare("redundant_change", {31'b0, change}, 32'h0);
    compare("redundant_drop", {24'b0, drop_cnt}, 32'h1);
    compare("redundant_count", {24'b0, active_count}, 32'h1);
    applyStimulus(8'h04, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    compare("off_change", {31'b0, change}, 32'h1);
    compare("off_dir", {31'b0, on_off}, 32'h0);
    compare("off_count", {24'b0, active_count}, 32'h0);

    $display("[TB] reset with three requests pending");
    applyStimulus(8'h31, 8'h31, 1'b1);
    compare("pre_reset_busy", {31'b0, busy}, 32'h1);
    doReset();
    compare("reset_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 8'h00, 1'b0);
    compare("no_replay_dev_on", {24'b0, dev_on}, 32'h0);

    $display("[TB] round-robin over all devices");
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < N; i++) begin
      applyStimulus(8'h00, 8'h00, 1'b0);
      compare("rr_change", {31'b0, change}, 32'h1);
      compare("rr_count", {24'b0, active_count}, i + 1);
      compare("rr_ready", {31'b0, req_ready[i]}, 32'h1);
    end

    $display("[TB] fairness after a grant to device 5");
    applyStimulus(8'h20, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h48, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    compare("fair_first_dev6", {24'b0, dev_on}, 32'h9F);
    applyStimulus(8'h00, 8'h00, 1'b0);
    compare("fair_then_dev3", {24'b0, dev_on}, 32'h97);

    $display("[TB] hold for four cycles");
    applyStimulus(8'h03, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h00, 8'h00, 1'b1);
      compare("hold_change", {31'b0, change}, 32'h0);
      compare("hold_busy", {31'b0, busy}, 32'h1);
    end
    applyStimulus(8'h00, 8'h00, 1'b0);
    compare("hold_resume0", {24'b0, dev_on}, 32'h96);
    applyStimulus(8'h00, 8'h00, 1'b0);
    compare("hold_resume1", {24'b0, dev_on}, 32'h94);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] drop counter saturation");
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'h01, 8'h00, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0);
    end
    compare("sat_drop", {24'b0, drop_cnt}, 32'hFF);
    compare("sat_count", {24'b0, active_count}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/iot_event_arbiter.md
Name: iot_event_arbiter

Overview:
- Collects on/off transition requests from N_DEV IoT device front-ends.
- Serialises them, one per cycle, onto the single `change`/`on_off` event interface of the active-device counter (`monitor`).
- Keeps a per-device on/off shadow. Only genuine state transitions reach the counter, so the counter never double-counts a device.
- Round-robin arbitration gives every device a bounded wait.

Parameters:
- N_DEV, 8, number of requesting devices (2..32).
- CNT_W, 8, width of active_count; must satisfy N_DEV < 2**CNT_W.
- DROP_W, 8, width of the saturating redundant-request counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_DEV  device i presents a request.
- req_on  in  N_DEV  requested state for device i (1=on, 0=off); valid only with req_valid[i].
- req_ready  out  N_DEV  device i can accept a request this cycle.
- hold  in  1  freezes arbitration; request capture continues.
- change  out  1  one-cycle event pulse to the counter.
- on_off  out  1  direction for the counter (1=up, 0=down); meaningful only when change=1.
- dev_on  out  N_DEV  shadow on/off state per device.
- active_count  out  CNT_W  number of devices currently on (popcount of dev_on).
- drop_cnt  out  DROP_W  count of redundant requests discarded, saturating.
- busy  out  1  at least one request is pending.

Behaviour:
- Reset (rst_n low, async): the following clear to 0 immediately:
  - pend[], pend_val[], dev_on, active_count, drop_cnt, change, on_off
  - round-robin pointer ptr is set to 0.
  - req_ready reads all-ones once pend is clear.
- Reset mid-operation discards all pending requests. The counter must be reset in the same cycle (system-level requirement).
- Capture:
  - req_ready[i] = !pend[i].
  - On a clock edge where req_valid[i] && req_ready[i]: set pend[i]<=1 and pend_val[i]<=req_on[i].
  - While pend[i]=1, device i is stalled and must hold its request.
- Arbitration runs each cycle when hold=0 and any pend bit is set:
  - Grant the first set pend bit searching ptr, ptr+1, …, N_DEV-1, 0, …, ptr-1.
  - On the edge: clear pend[g] and set ptr <= (g+1) mod N_DEV.
  - At most one grant per cycle.
  - When hold=1: no grant, ptr unchanged, change<=0.
- Grant action:
  - Genuine (pend_val[g] != dev_on[g]): change<=1, on_off<=pend_val[g], dev_on[g]<=pend_val[g]; active_count increments (on) or decrements (off).
  - Redundant (pend_val[g] == dev_on[g]): change<=0, on_off unchanged, and drop_cnt<=drop_cnt+1 saturating at all-ones.
- Outputs:
  - change, on_off, dev_on and active_count are registered.
  - change is high for exactly one cycle per genuine grant, and low on every cycle without one.
- Latency:
  - Request accepted at edge k → earliest grant at edge k+1 → change visible after edge k+1.
  - Worst case with all devices requesting: N_DEV grant cycles.
- Simultaneous events:
  - Capture and grant of the same device cannot coincide (ready is low while pending).
  - A grant and a new capture on different devices in the same cycle are both performed.
- Width rules:
  - active_count never wraps; 0 ≤ active_count ≤ N_DEV by construction.
  - The downstream counter's wrap-around is therefore never exercised by this block.
- busy = |pend.

Decomposition:
- Package iot_pkg holds constants N_DEV_DEF=8 and CNT_W_DEF=8, plus localparam PTR_W = $clog2(N_DEV).
- Sub-module iot_rr_arbiter (combinational):
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, grant index, grant_valid.
- The top level holds the pend/pend_val/dev_on registers, ptr, counters and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 pending requests → all outputs 0 asynchronously, req_ready=8'hFF, busy=0; after release, nothing is replayed.
- Single on: req_valid[2]=1, req_on[2]=1 for one cycle → exactly one change=1/on_off=1 pulse two edges later; dev_on=8'h04; active_count=1.
- Redundant: repeat on-request for device 2 → change stays 0, drop_cnt=1, active_count=1. Then an off-request → change=1, on_off=0, active_count=0.
- Round-robin: all 8 devices request on in the same cycle with ptr=0 → grants 0..7 on 8 consecutive cycles, change=1 each cycle, active_count ramps 1..8, req_ready[i] returns to 1 after its grant.
- Fairness / hold:
  - After a grant to device 5, requests on devices 3 and 6 → 6 is granted before 3.
  - hold=1 for 4 cycles → no change pulses and busy=1 throughout; after release, grants resume in order.
- Saturation: 300 redundant off-requests on device 0 (DROP_W=8) → drop_cnt=255 and stays there; active_count unchanged at 0.
